// File: rtl/puzzle_sequencer.sv
// Purpose: schedules the wake-up puzzle engines one at a time until enough consecutive solves silence the alarm.
// Latency: alarmOn rise -> startEq on the 2nd edge; correct eqDone -> next startEq 2 cycles later.
// Backpressure: none; engines answer with single-cycle eqDone pulses and the sequencer waits indefinitely up to the time limit.
module puzzle_sequencer #(
    parameter int NUM_EQ        = 3,
    parameter int SOLVES_NEEDED = 3,
    parameter int MAX_TRIES     = 3,
    parameter int TIME_LIMIT    = 60
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              alarmOn,
    input  logic [6:0]        OngoingTimer,
    input  logic [NUM_EQ-1:0] eqDone,
    input  logic [NUM_EQ-1:0] eqCorrect,
    output logic [NUM_EQ-1:0] startEq,
    output logic [1:0]        activeEq,
    output logic [2:0]        solvedCount,
    output logic [1:0]        triesLeft,
    output logic              timeout,
    output logic              alarmSilence,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_SOLVED,
        S_FAIL,
        S_SILENCE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [1:0]        r_ptr;
    logic [1:0]        w_ptr;
    logic [2:0]        r_solved;
    logic [2:0]        w_solved;
    logic [1:0]        r_tries;
    logic [1:0]        w_tries;
    logic [6:0]        r_stamp;
    logic [6:0]        w_stamp;
    logic              r_timeout;
    logic              w_timeout;

    logic [NUM_EQ-1:0] w_onehot;
    logic              w_done;
    logic              w_correct;
    logic [1:0]        w_ptr_inc;
    logic [6:0]        w_elapsed;
    logic [2:0]        w_solved_inc;

    // Wrap-around subtraction keeps the elapsed time right across the 127->0 rollover.
    assign w_elapsed    = OngoingTimer - r_stamp;
    assign w_ptr_inc    = (r_ptr == 2'(NUM_EQ - 1)) ? 2'd0 : r_ptr + 2'd1;
    assign w_solved_inc = r_solved + 3'd1;

    // Select the lanes of the engine currently being served; all other lanes are ignored.
    always_comb begin
        w_onehot  = '0;
        w_done    = 1'b0;
        w_correct = 1'b0;
        for (int i = 0; i < NUM_EQ; i++) begin
            if (r_ptr == 2'(i)) begin
                w_onehot[i] = 1'b1;
                w_done      = eqDone[i];
                w_correct   = eqCorrect[i];
            end
        end
    end

    // Next-state and next-register values; a dropped alarm overrides everything.
    always_comb begin
        w_next    = r_state;
        w_ptr     = r_ptr;
        w_solved  = r_solved;
        w_tries   = r_tries;
        w_stamp   = r_stamp;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ptr    = 2'd0;
                w_solved = 3'd0;
                w_tries  = 2'(MAX_TRIES);
                if (alarmOn) begin
                    w_next  = S_LAUNCH;
                    w_stamp = OngoingTimer;
                end
            end
            S_LAUNCH: begin
                w_next = S_WAIT;
            end
            S_WAIT: begin
                // A result in the same cycle as the deadline takes precedence over the timeout.
                if (w_done) begin
                    if (w_correct) begin
                        w_next = S_SOLVED;
                    end else if (r_tries > 2'd1) begin
                        w_tries = r_tries - 2'd1;
                        w_next  = S_LAUNCH;
                    end else begin
                        w_tries = 2'd0;
                        w_next  = S_FAIL;
                    end
                end else if (w_elapsed >= 7'(TIME_LIMIT)) begin
                    w_next    = S_FAIL;
                    w_timeout = 1'b1;
                end
            end
            S_SOLVED: begin
                w_solved = w_solved_inc;
                if (w_solved_inc == 3'(SOLVES_NEEDED)) begin
                    w_next = S_SILENCE;
                end else begin
                    w_ptr   = w_ptr_inc;
                    w_tries = 2'(MAX_TRIES);
                    w_stamp = OngoingTimer;
                    w_next  = S_LAUNCH;
                end
            end
            S_FAIL: begin
                w_solved = 3'd0;
                w_ptr    = w_ptr_inc;
                w_tries  = 2'(MAX_TRIES);
                w_stamp  = OngoingTimer;
                w_next   = S_LAUNCH;
            end
            S_SILENCE: begin
                w_solved = 3'(SOLVES_NEEDED);
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (!alarmOn) begin
            w_next    = S_IDLE;
            w_ptr     = 2'd0;
            w_solved  = 3'd0;
            w_tries   = 2'(MAX_TRIES);
            w_timeout = 1'b0;
        end
    end

    // State and bookkeeping registers with synchronous active-low reset.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_state   <= S_IDLE;
            r_ptr     <= 2'd0;
            r_solved  <= 3'd0;
            r_tries   <= 2'(MAX_TRIES);
            r_stamp   <= 7'd0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_ptr     <= w_ptr;
            r_solved  <= w_solved;
            r_tries   <= w_tries;
            r_stamp   <= w_stamp;
            r_timeout <= w_timeout;
        end
    end

    assign startEq      = (r_state == S_LAUNCH) ? w_onehot : '0;
    assign activeEq     = r_ptr;
    assign solvedCount  = r_solved;
    assign triesLeft    = r_tries;
    assign timeout      = r_timeout;
    assign alarmSilence = (r_state == S_SILENCE);
    assign busy         = (r_state != S_IDLE);

endmodule
